// File: rtl/module_7seg_scan_pkg.sv
// Segment glyph table and hex/BCD decode helper shared by the display scanner.
// Segment bit order is [6]=a .. [0]=g, 1 = lit.
package pkg_7seg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h7E;
  localparam seg_t SEG_1   = 7'h30;
  localparam seg_t SEG_2   = 7'h6D;
  localparam seg_t SEG_3   = 7'h79;
  localparam seg_t SEG_4   = 7'h33;
  localparam seg_t SEG_5   = 7'h5B;
  localparam seg_t SEG_6   = 7'h5F;
  localparam seg_t SEG_7   = 7'h70;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h7B;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h1F;
  localparam seg_t SEG_C   = 7'h4E;
  localparam seg_t SEG_D   = 7'h3D;
  localparam seg_t SEG_E   = 7'h4F;
  localparam seg_t SEG_F   = 7'h47;
  localparam seg_t SEG_OFF = 7'h00;

  // A..F render as glyphs only in hex mode; in BCD mode they are blanked.
  function automatic seg_t hex2seg(input logic [3:0] d, input logic hex_mode);
    seg_t r;
    case (d)
      4'h0:    r = SEG_0;
      4'h1:    r = SEG_1;
      4'h2:    r = SEG_2;
      4'h3:    r = SEG_3;
      4'h4:    r = SEG_4;
      4'h5:    r = SEG_5;
      4'h6:    r = SEG_6;
      4'h7:    r = SEG_7;
      4'h8:    r = SEG_8;
      4'h9:    r = SEG_9;
      4'hA:    r = SEG_A;
      4'hB:    r = SEG_B;
      4'hC:    r = SEG_C;
      4'hD:    r = SEG_D;
      4'hE:    r = SEG_E;
      default: r = SEG_F;
    endcase
    if ((d > 4'h9) && !hex_mode) begin
      r = SEG_OFF;
    end
    return r;
  endfunction

endpackage

// File: rtl/module_7seg_scan_decoder.sv
// Combinational nibble-to-segment decoder with a forced-blank input.
// Output is active-high (1 = lit); pin polarity is applied by the caller.
module module_7seg_decoder
  import pkg_7seg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output seg_t       seg
);

  assign seg = blank ? SEG_OFF : hex2seg(nibble, hex_mode);

endmodule

// File: rtl/module_7seg_scan.sv
// Time-multiplexed N-digit 7-segment scanner with frame-aligned (tear-free) updates,
// leading-zero blanking, per-digit blink and configurable pin polarity.
module module_7seg_scan
  import pkg_7seg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIV            = 27000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    hex_mode,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  localparam seg_t                  SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam seg_t                  SEG_IDLE = SEG_OFF ^ SEG_POL;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic [3:0]              cur_nibble;
  logic                    cur_lzb;
  logic                    cur_blink;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [NUM_DIGITS-1:0]   lzb_vec;
  logic                    zero_run;
  seg_t                    dec_seg;

  assign tick       = (cnt_q == CNT_MAX);
  assign frame_done = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    zero_run = 1'b1;
    lzb_vec  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (active_q[4*k +: 4] == 4'h0);
      if (k != 0) begin
        lzb_vec[k] = zero_run;
      end
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_lzb    = 1'b0;
    cur_blink  = 1'b0;
    an_onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble   = active_q[4*i +: 4];
        cur_lzb      = lzb_vec[i];
        cur_blink    = blink_mask[i];
        an_onehot[i] = 1'b1;
      end
    end
    cur_blank = (lzb_en && cur_lzb) || (blink_phase_q && cur_blink);
  end

  module_7seg_decoder u_dec (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .blank    (cur_blank),
    .seg      (dec_seg)
  );

  // The digit under idx_q is committed to the pins at the end of its slot, so a whole
  // frame (digit 0 .. N-1) is drawn from one active word and the swap lands between frames.
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = dec_seg ^ SEG_POL;
      an_d  = an_onehot ^ AN_IDLE;
    end
  end

  // A strobe coincident with the frame boundary bypasses pending and supersedes it.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_done) begin
      if (data_valid) begin
        active_d = data_in;
      end else if (pend_vld_q) begin
        active_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (data_valid) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_done) begin
      if (blk_cnt_q == BLK_MAX) begin
        blk_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      seg_q         <= SEG_IDLE;
      an_q          <= AN_IDLE;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_module_7seg_scan.sv
// Directed bench: DIV=4, NUM_DIGITS=4, BLINK_FRAMES=2, plus an inverted-polarity instance.
module tb_module_7seg_scan;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        data_valid;
  logic        hex_mode;
  logic        lzb_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  logic [15:0] pol_data;
  logic        pol_valid;
  logic [3:0]  pol_blink;
  logic [6:0]  pol_seg;
  logic [3:0]  pol_an;
  logic        pol_fd;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  module_7seg_scan #(
    .NUM_DIGITS(4), .DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .hex_mode(hex_mode),
    .lzb_en(lzb_en), .blink_mask(blink_mask), .seg(seg), .an(an), .frame_done(frame_done)
  );

  module_7seg_scan #(
    .NUM_DIGITS(4), .DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
  ) u_pol (
    .clk(clk), .rst(rst), .data_in(pol_data), .data_valid(pol_valid), .hex_mode(hex_mode),
    .lzb_en(lzb_en), .blink_mask(pol_blink), .seg(pol_seg), .an(pol_an), .frame_done(pol_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-done pulses since reset; the blink phase of a frame is (pulses/2) mod 2.
  always @(negedge clk) begin
    if (rst) fd_cnt <= 0;
    else if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic chk_slot(input int n, input string tag, input logic [3:0] an_exp,
                          input logic [6:0] seg_exp);
    repeat (n) @(posedge clk);
    #1;
    check({tag, "_an"}, {12'h0, an}, {12'h0, an_exp});
    check({tag, "_seg"}, {9'h0, seg}, {9'h0, seg_exp});
  endtask

  // s packs the unblinked digit glyphs as {d3,d2,d1,d0}.
  task automatic scan_frame(input string tag, input logic [27:0] s);
    logic       phase;
    logic [6:0] e;
    logic [3:0] a;
    phase = ((fd_cnt / 2) % 2) == 1;
    for (int k = 0; k < 4; k++) begin
      e = s[7*k +: 7];
      if (phase && blink_mask[k]) e = 7'h00;
      a = ~(4'b0001 << k);
      chk_slot(4, $sformatf("%s_d%0d", tag, k), a, e);
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    check("fd_seen", {15'h0, frame_done}, 16'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_period();
    int n;
    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    check("fd_period", n[15:0], 16'd16);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = 16'h0;
    data_valid = 1'b0;
    hex_mode   = 1'b0;
    lzb_en     = 1'b0;
    blink_mask = 4'b0000;
    pol_data   = 16'h0;
    pol_valid  = 1'b0;
    pol_blink  = 4'b0000;

    // Reset state on both polarities.
    repeat (2) @(negedge clk);
    check("rst_seg", {9'h0, seg}, 16'h00);
    check("rst_an", {12'h0, an}, 16'hF);
    check("rst_fd", {15'h0, frame_done}, 16'h0);
    check("pol_rst_seg", {9'h0, pol_seg}, 16'h7F);
    check("pol_rst_an", {12'h0, pol_an}, 16'h0);
    rst = 1'b0;

    // First anode appears after DIV clocks.
    chk_slot(3, "first_idle", 4'hF, 7'h00);
    chk_slot(1, "first_e", 4'hE, 7'h7E);

    // Asynchronous assertion mid-scan.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg", {9'h0, seg}, 16'h00);
    check("async_an", {12'h0, an}, 16'hF);
    check("async_pol_seg", {9'h0, pol_seg}, 16'h7F);
    check("async_pol_an", {12'h0, pol_an}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Scan 1234 and frame period.
    @(negedge clk);
    data_in    = 16'h1234;
    data_valid = 1'b1;
    pol_data   = 16'h8888;
    pol_valid  = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    pol_valid  = 1'b0;
    measure_period();
    scan_frame("scan1234", {7'h30, 7'h6D, 7'h79, 7'h33});

    // Two strobes mid-frame: current frame untouched, latest value shown next frame.
    hex_mode = 1'b1;
    strobe(16'h5678);
    strobe(16'h9ABC);
    chk_slot(1, "tear_d0", 4'hE, 7'h33);
    chk_slot(4, "tear_d1", 4'hD, 7'h79);
    chk_slot(4, "tear_d2", 4'hB, 7'h6D);
    chk_slot(4, "tear_d3", 4'h7, 7'h30);
    scan_frame("new9abc", {7'h7B, 7'h77, 7'h1F, 7'h4E});

    // Pending write, then a strobe coincident with frame_done overrides it.
    strobe(16'h1111);
    repeat (14) @(negedge clk);
    check("fd_coinc", {15'h0, frame_done}, 16'h1);
    data_in    = 16'h2468;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    scan_frame("coinc", {7'h6D, 7'h33, 7'h5F, 7'h7F});
    scan_frame("coinc2", {7'h6D, 7'h33, 7'h5F, 7'h7F});

    // BCD blanking, hex glyphs, leading-zero blanking.
    hex_mode = 1'b0;
    lzb_en   = 1'b1;
    strobe(16'h00AF);
    wait_fd();
    scan_frame("bcd_af", {7'h00, 7'h00, 7'h00, 7'h00});
    hex_mode = 1'b1;
    scan_frame("hex_af", {7'h00, 7'h00, 7'h77, 7'h47});
    strobe(16'h0000);
    wait_fd();
    scan_frame("lzb0000", {7'h00, 7'h00, 7'h00, 7'h7E});
    strobe(16'h0305);
    wait_fd();
    scan_frame("lzb0305", {7'h00, 7'h79, 7'h7E, 7'h5B});

    // Blink on digit 0 over four frames covers both phases.
    lzb_en     = 1'b0;
    blink_mask = 4'b0001;
    strobe(16'h0000);
    wait_fd();
    for (int f = 0; f < 4; f++) begin
      scan_frame($sformatf("blink%0d", f), {7'h7E, 7'h7E, 7'h7E, 7'h7E});
    end
    blink_mask = 4'b0000;

    // Inverted polarity instance showing 8888.
    check("pol_d3_an", {12'h0, pol_an}, 16'h8);
    check("pol_d3_seg", {9'h0, pol_seg}, 16'h00);
    repeat (4) @(posedge clk);
    #1;
    check("pol_d0_an", {12'h0, pol_an}, 16'h1);
    check("pol_d0_seg", {9'h0, pol_seg}, 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
